// File: rtl/list_walk_scheduler.sv
// Time-slotted linked-list walker sharing one pipelined next-pointer memory between requesters.
// Optional loop guard enabled by defining LIST_WALK_LOOP_GUARD_EN.
module list_walk_scheduler #(
  parameter int unsigned N     = 16,
  parameter int unsigned LAT   = 3,
  parameter int unsigned N_REQ = 4,
  localparam int unsigned PTR_W = $clog2(N),
  localparam int unsigned ID_W  = $clog2(N_REQ),
  localparam int unsigned PH_W  = (LAT > 1) ? $clog2(LAT) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_vld,
  input  logic [N_REQ*PTR_W-1:0] req_start,
  output logic [N_REQ-1:0]       req_rdy,
  output logic                   mem_re,
  output logic [PTR_W-1:0]       mem_ra,
  input  logic [PTR_W-1:0]       mem_rd,
  output logic                   out_vld,
  output logic [PTR_W-1:0]       out_ptr,
  output logic [ID_W-1:0]        out_id,
  output logic                   done_vld,
  output logic [ID_W-1:0]        done_id,
  output logic                   err
);

  logic [PH_W-1:0] ph;
  logic [LAT-1:0]  busy;
  logic [ID_W-1:0] slot_id [LAT];
  logic [ID_W-1:0] rr_ptr;

  logic            cur_busy;
  logic            rd_live;
  logic            walk_end;
  logic            abort;
  logic            cont;
  logic            slot_open;
  logic            pick_vld;
  logic [ID_W-1:0] pick;
  logic [ID_W:0]   sum;
  logic [PTR_W-1:0] pick_start;
  logic            grant;

  assign cur_busy = busy[ph];
  assign rd_live  = cur_busy && (mem_rd != '0);
  assign walk_end = cur_busy && (mem_rd == '0);
  assign cont     = rd_live && !abort;
  assign slot_open = !cur_busy || walk_end || abort;

  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    sum      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(N_REQ)) sum = sum - (ID_W+1)'(N_REQ);
      if (!pick_vld && req_vld[sum[ID_W-1:0]]) begin
        pick_vld = 1'b1;
        pick     = sum[ID_W-1:0];
      end
    end
  end

  assign pick_start = req_start[pick*PTR_W +: PTR_W];

  // A zero start would report done next cycle, colliding with the done of the
  // walk ending in this slot, so such a grant is held off for one slot turn.
  assign grant = rst && slot_open && pick_vld &&
                 !((pick_start == '0) && (walk_end || abort));

  always_comb begin
    req_rdy = '0;
    if (grant) req_rdy[pick] = 1'b1;
  end

  assign mem_re = cont || (grant && (pick_start != '0));
  assign mem_ra = cont ? mem_rd : (mem_re ? pick_start : '0);

`ifdef LIST_WALK_LOOP_GUARD_EN
  localparam int unsigned HOP_W = $clog2(N + 1);
  logic [HOP_W-1:0] hop [LAT];

  assign abort = rd_live && (hop[ph] == HOP_W'(N));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) hop[i] <= '0;
    end else if (grant && (pick_start != '0)) begin
      hop[ph] <= HOP_W'(1);
    end else if (cont) begin
      hop[ph] <= hop[ph] + 1'b1;
    end
  end
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph       <= '0;
      busy     <= '0;
      rr_ptr   <= '0;
      for (int i = 0; i < LAT; i++) slot_id[i] <= '0;
      out_vld  <= 1'b0;
      out_ptr  <= '0;
      out_id   <= '0;
      done_vld <= 1'b0;
      done_id  <= '0;
      err      <= 1'b0;
    end else begin
      ph       <= (ph == PH_W'(LAT - 1)) ? '0 : ph + 1'b1;
      out_vld  <= mem_re;
      out_ptr  <= mem_ra;
      out_id   <= cont ? slot_id[ph] : pick;
      done_vld <= walk_end || abort || (grant && (pick_start == '0));
      done_id  <= (walk_end || abort) ? slot_id[ph] : pick;
      err      <= abort;
      if (walk_end || abort) busy[ph] <= 1'b0;
      if (grant) begin
        rr_ptr <= (pick == ID_W'(N_REQ - 1)) ? '0 : pick + 1'b1;
        if (pick_start != '0) begin
          busy[ph]    <= 1'b1;
          slot_id[ph] <= pick;
        end
      end
    end
  end

endmodule

// File: tb/tb_list_walk_scheduler.sv
// Self-checking bench for list_walk_scheduler against a walk-level reference model.
module tb_list_walk_scheduler;
  localparam int N = 16, LAT = 3, N_REQ = 4, PTR_W = 4, ID_W = 2, MAXC = 1024;
`ifdef LIST_WALK_LOOP_GUARD_EN
  localparam int LIMIT = N;
`else
  localparam int LIMIT = 64;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N_REQ-1:0] req_vld = '0;
  logic [N_REQ*PTR_W-1:0] req_start = '0;
  logic [N_REQ-1:0] req_rdy;
  logic mem_re;
  logic [PTR_W-1:0] mem_ra;
  logic [PTR_W-1:0] mem_rd = '0;
  logic out_vld;
  logic [PTR_W-1:0] out_ptr;
  logic [ID_W-1:0] out_id;
  logic done_vld;
  logic [ID_W-1:0] done_id;
  logic err;

  always #5 clk = ~clk;

  list_walk_scheduler #(.N(N), .LAT(LAT), .N_REQ(N_REQ)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_start(req_start), .req_rdy(req_rdy),
    .mem_re(mem_re), .mem_ra(mem_ra), .mem_rd(mem_rd), .out_vld(out_vld),
    .out_ptr(out_ptr), .out_id(out_id), .done_vld(done_vld), .done_id(done_id), .err(err)
  );

  int errors = 0;
  int checks = 0;
  int tbl [N];
  bit pend [N_REQ];
  int pstart [N_REQ];
  bit memv [LAT];
  int mema [LAT];
  int cyc, cur;
  int rr;
  int busy_until [LAT];
  int ended_at [LAT];
  bit e_ov [MAXC];
  int e_op [MAXC];
  int e_oid [MAXC];
  bit e_dv [MAXC];
  int e_did [MAXC];
  bit e_err [MAXC];
  logic [31:0] obs_vec, exp_vec;
  logic [N_REQ-1:0] obs_rdy;

  function automatic void put_out(int c, int p, int id);
    if (c < MAXC) begin e_ov[c] = 1'b1; e_op[c] = p; e_oid[c] = id; end
  endfunction

  function automatic void put_done(int c, int id, bit er);
    if (c < MAXC) begin e_dv[c] = 1'b1; e_did[c] = id; e_err[c] = er; end
  endfunction

  function automatic void model_reset();
    cyc = 0;
    rr = 0;
    for (int s = 0; s < LAT; s++) begin busy_until[s] = 0; ended_at[s] = -1; end
    for (int c = 0; c < MAXC; c++) begin
      e_ov[c] = 1'b0; e_op[c] = 0; e_oid[c] = 0; e_dv[c] = 1'b0; e_did[c] = 0; e_err[c] = 1'b0;
    end
    for (int i = 0; i < N_REQ; i++) pend[i] = 1'b0;
  endfunction

  // One clock cycle: drive requests and memory, predict, sample, apply handshakes.
  task automatic tick();
    int s, g, p, j, ix;
    logic [N_REQ-1:0] m_rdy;
    cur = cyc;
    s = cyc % LAT;
    for (int i = 0; i < N_REQ; i++) begin
      req_vld[i] = pend[i];
      req_start[i*PTR_W +: PTR_W] = PTR_W'(pstart[i]);
    end
    mem_rd = memv[s] ? PTR_W'(tbl[mema[s]]) : PTR_W'($urandom_range(1, N - 1));
    m_rdy = '0;
    if (busy_until[s] <= cyc) begin
      g = -1;
      for (int k = 0; k < N_REQ; k++) begin
        ix = (rr + k) % N_REQ;
        if (g < 0 && pend[ix]) g = ix;
      end
      if (g >= 0 && pstart[g] == 0 && ended_at[s] == cyc) g = -1;
      if (g >= 0) begin
        m_rdy[g] = 1'b1;
        rr = (g + 1) % N_REQ;
        if (pstart[g] == 0) begin
          put_done(cyc + 1, g, 1'b0);
        end else begin
          p = pstart[g];
          j = 0;
          while (p != 0 && j < LIMIT) begin
            put_out(cyc + j * LAT + 1, p, g);
            p = tbl[p];
            j++;
          end
          if (p == 0) begin
            put_done(cyc + j * LAT + 1, g, 1'b0);
            busy_until[s] = cyc + j * LAT;
            ended_at[s] = cyc + j * LAT;
          end else begin
`ifdef LIST_WALK_LOOP_GUARD_EN
            put_done(cyc + j * LAT + 1, g, 1'b1);
            busy_until[s] = cyc + j * LAT;
            ended_at[s] = cyc + j * LAT;
`else
            busy_until[s] = 1 << 30;
`endif
          end
        end
      end
    end
    #3;
    exp_vec = '0;
    obs_vec = '0;
    exp_vec[3:0] = m_rdy;
    obs_vec[3:0] = req_rdy;
    exp_vec[4] = e_ov[cyc + 1];
    obs_vec[4] = mem_re;
    if (e_ov[cyc + 1]) exp_vec[8:5] = PTR_W'(e_op[cyc + 1]);
    if (mem_re) obs_vec[8:5] = mem_ra;
    exp_vec[9] = e_ov[cyc];
    obs_vec[9] = out_vld;
    if (e_ov[cyc]) begin exp_vec[13:10] = PTR_W'(e_op[cyc]); exp_vec[15:14] = ID_W'(e_oid[cyc]); end
    if (out_vld) begin obs_vec[13:10] = out_ptr; obs_vec[15:14] = out_id; end
    exp_vec[16] = e_dv[cyc];
    obs_vec[16] = done_vld;
    if (e_dv[cyc]) begin exp_vec[18:17] = ID_W'(e_did[cyc]); exp_vec[19] = e_err[cyc]; end
    if (done_vld) begin obs_vec[18:17] = done_id; obs_vec[19] = err; end
    obs_rdy = req_rdy;
    for (int i = 0; i < N_REQ; i++) if (req_vld[i] && req_rdy[i]) pend[i] = 1'b0;
    memv[s] = mem_re;
    mema[s] = int'(mem_ra);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_vld = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic clear_tbl();
    for (int i = 0; i < N; i++) tbl[i] = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_vld = '1;
    req_start = 16'h9273;
    #1;
    checks++;
    if ({req_rdy, mem_re, mem_ra, out_vld, out_ptr, out_id, done_vld, done_id, err} !== '0)
      begin errors++; $display("FAIL reset_state got rdy=%b re=%b ov=%b dv=%b exp all 0",
                               req_rdy, mem_re, out_vld, done_vld); end
    do_reset();
    // Chain 1 -> 2 -> ... -> 15 -> 0, three long walks in flight.
    clear_tbl();
    for (int i = 1; i < N - 1; i++) tbl[i] = i + 1;
    pend[0] = 1; pstart[0] = 1; pend[1] = 1; pstart[1] = 6; pend[2] = 1; pstart[2] = 11;
    repeat (6) begin
      tick();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL reset_pre cyc=%0d got=%h exp=%h", cur, obs_vec, exp_vec);
      end
    end
    req_vld = '1;
    rst = 1'b0;
    #1;
    checks++;
    if ({req_rdy, mem_re, mem_ra, out_vld, out_ptr, out_id, done_vld, done_id, err} !== '0)
      begin errors++; $display("FAIL reset_midwalk got rdy=%b re=%b ov=%b dv=%b exp all 0",
                               req_rdy, mem_re, out_vld, done_vld); end
    @(posedge clk);
    #1;
    checks++;
    if ({req_rdy, mem_re, out_vld, done_vld} !== '0) begin
      errors++; $display("FAIL reset_hold got rdy=%b re=%b ov=%b dv=%b exp 0",
                         req_rdy, mem_re, out_vld, done_vld);
    end
    rst = 1'b1;
    model_reset();
    repeat (8) begin
      tick();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL reset_stale cyc=%0d got=%h exp=%h", cur, obs_vec, exp_vec);
      end
    end
    pend[3] = 1; pstart[3] = 13;
    repeat (14) begin
      tick();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL reset_fresh cyc=%0d got=%h exp=%h", cur, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_single_walk();
    do_reset();
    clear_tbl();
    tbl[1] = 5; tbl[5] = 3; tbl[3] = 10; tbl[10] = 0;
    pend[0] = 1; pstart[0] = 1;
    repeat (16) begin
      tick();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL single_walk cyc=%0d got=%h exp=%h", cur, obs_vec, exp_vec);
      end
      if (cur == 13) begin
        checks++;
        if (obs_vec[16] !== 1'b1 || obs_vec[18:17] !== 2'd0) begin
          errors++; $display("FAIL single_done got dv=%b id=%0d exp dv=1 id=0",
                             obs_vec[16], obs_vec[18:17]);
        end
      end
    end
  endtask

  task automatic test_all_requesters();
    do_reset();
    clear_tbl();
    tbl[7] = 15; tbl[15] = 8; tbl[2] = 4; tbl[9] = 14; tbl[14] = 11; tbl[11] = 13; tbl[13] = 12;
    pstart[0] = 7; pstart[1] = 6; pstart[2] = 2; pstart[3] = 9;
    for (int i = 0; i < N_REQ; i++) pend[i] = 1;
    repeat (26) begin
      tick();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL all_req cyc=%0d got=%h exp=%h", cur, obs_vec, exp_vec);
      end
      if (cur == 4) begin
        checks++;
        if (obs_rdy !== 4'b1000) begin
          errors++; $display("FAIL all_req_grant3 got rdy=%b exp 1000", obs_rdy);
        end
      end
    end
  endtask

  task automatic test_zero_start();
    do_reset();
    clear_tbl();
    pend[2] = 1; pstart[2] = 0;
    repeat (5) begin
      tick();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL zero_start cyc=%0d got=%h exp=%h", cur, obs_vec, exp_vec);
      end
      if (cur == 1) begin
        checks++;
        if (obs_vec[16] !== 1'b1 || obs_vec[18:17] !== 2'd2 || obs_vec[9] !== 1'b0) begin
          errors++; $display("FAIL zero_done got dv=%b id=%0d ov=%b exp dv=1 id=2 ov=0",
                             obs_vec[16], obs_vec[18:17], obs_vec[9]);
        end
      end
    end
  endtask

  task automatic test_fairness();
    int last;
    int gid;
    do_reset();
    clear_tbl();
    last = -1;
    pstart[1] = 5; pstart[3] = 5;
    repeat (24) begin
      pend[1] = 1; pend[3] = 1;
      tick();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL fairness cyc=%0d got=%h exp=%h", cur, obs_vec, exp_vec);
      end
      if (obs_rdy != '0) begin
        gid = obs_rdy[3] ? 3 : 1;
        if (last >= 0) begin
          checks++;
          if (gid == last) begin
            errors++; $display("FAIL fair_alt cyc=%0d got grant=%0d exp other than %0d",
                               cur, gid, last);
          end
        end
        last = gid;
      end
    end
  endtask

  task automatic test_loop();
    int outs, dones;
    do_reset();
    clear_tbl();
    tbl[4] = 8; tbl[8] = 4;
    outs = 0; dones = 0;
    pend[0] = 1; pstart[0] = 4;
    repeat (60) begin
      tick();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL loop cyc=%0d got=%h exp=%h", cur, obs_vec, exp_vec);
      end
      outs += int'(obs_vec[9]);
      dones += int'(obs_vec[16]);
    end
`ifdef LIST_WALK_LOOP_GUARD_EN
    checks++;
    if (outs != 16 || dones != 1) begin
      errors++; $display("FAIL loop_guard got outs=%0d dones=%0d exp 16 and 1", outs, dones);
    end
    pend[1] = 1; pstart[1] = 1;
    repeat (8) begin
      tick();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL loop_reuse cyc=%0d got=%h exp=%h", cur, obs_vec, exp_vec);
      end
    end
`else
    checks++;
    if (outs != 20 || dones != 0) begin
      errors++; $display("FAIL loop_forever got outs=%0d dones=%0d exp 20 and 0", outs, dones);
    end
`endif
  endtask

  task automatic test_random();
    int perm [N-1];
    int k, t;
    do_reset();
    clear_tbl();
    for (int i = 0; i < N - 1; i++) perm[i] = i + 1;
    for (int i = N - 2; i > 0; i--) begin
      k = $urandom_range(0, i);
      t = perm[i]; perm[i] = perm[k]; perm[k] = t;
    end
    // Chains follow the shuffled order, so every list terminates.
    for (int i = 0; i < N - 2; i++) tbl[perm[i]] = ($urandom_range(0, 3) != 0) ? perm[i + 1] : 0;
    repeat (600) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!pend[i] && $urandom_range(0, 9) < 3) begin
          pend[i] = 1;
          pstart[i] = $urandom_range(0, N - 1);
        end
      end
      tick();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cur, obs_vec, exp_vec);
      end
    end
  endtask

  initial begin
    for (int s = 0; s < LAT; s++) begin memv[s] = 1'b0; mema[s] = 0; end
    for (int i = 0; i < N_REQ; i++) pstart[i] = 0;
    model_reset();
    test_reset();
    test_single_walk();
    test_all_requesters();
    test_zero_start();
    test_fairness();
    test_loop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/list_walk_scheduler.md
Name: list_walk_scheduler

Overview:
- Shares one pipelined linked-list next-pointer memory between N_REQ independent walk requesters.
- Memory read latency is fixed at LAT cycles. The scheduler keeps up to LAT walks in flight, one per time slot, so it issues one read per cycle with no bubbles.
- Accepts start pointers through round-robin arbitration, chases each list until the null pointer (0), and emits every visited node tagged with requester id, plus a per-walk done pulse.

Parameters:
- N, 16, number of list nodes; PTR_W = $clog2(N); pointer 0 is null.
- LAT, 3, memory read latency in cycles (>=1); also the number of walk slots.
- N_REQ, 4, number of requesters (>=2); ID_W = $clog2(N_REQ).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- req_vld  in  N_REQ  per-requester walk request valid
- req_start  in  N_REQ*PTR_W  per-requester start pointer; requester i uses bits [i*PTR_W +: PTR_W]
- req_rdy  out  N_REQ  one-hot grant; request accepted when req_vld[i] & req_rdy[i]
- mem_re  out  1  memory read enable
- mem_ra  out  PTR_W  memory read address
- mem_rd  in  PTR_W  next pointer of the address read exactly LAT cycles earlier
- out_vld  out  1  visited-node output valid
- out_ptr  out  PTR_W  visited node
- out_id  out  ID_W  requester that owns the walk
- done_vld  out  1  walk-complete pulse
- done_id  out  ID_W  requester whose walk completed
- err  out  1  loop-guard abort flag, qualified by done_vld (tied 0 when the feature is off)

Behaviour:
- Phase counter ph runs 0..LAT-1 and wraps every cycle. Slot s owns every cycle with ph==s.
- Per slot state: busy, id. busy=1 means a read issued by this slot LAT cycles ago returns on mem_rd now.
- Each cycle, for slot s=ph:
  - busy & mem_rd!=0: mem_re=1, mem_ra=mem_rd. Slot stays busy. Node mem_rd is emitted.
  - busy & mem_rd==0: walk ends. done is emitted with slot id. Slot becomes free in this same cycle and may accept a new request (no bubble).
  - slot free (or just freed): round-robin arbiter grants at most one requester with req_vld=1.
    - Grant with start!=0: mem_re=1, mem_ra=start. busy<=1, id<=grantee. Node start is emitted.
    - Grant with start==0: request consumed. done is emitted the next cycle with that id. Slot stays free.
- req_rdy is nonzero only in a cycle whose slot is free or freeing. It is combinational from req_vld, slot state and mem_rd.
- Round-robin: priority pointer resets to 0. After granting i, the pointer moves to (i+1) mod N_REQ. No grant leaves the pointer unchanged.
- mem_re/mem_ra are combinational (mem_rd -> mem_ra is an allowed path). A mem_rd value is ignored when its slot is not busy.
- out_vld/out_ptr/out_id are registered, one cycle after the matching mem_re. done_vld/done_id/err are registered, one cycle after the terminating cycle.
- Latency for a walk of k nodes accepted at cycle t: node j (j=0..k-1) appears on out_* at t+j*LAT+1; done at t+k*LAT+1.
- At most one out_vld and one done_vld per cycle; the two may coincide for different slots.
- A requester may hold several walks in flight. Done order follows completion, not acceptance.
- Reset (async, any time including mid-walk): ph=0, all slots free, rr pointer=0. All outputs 0: req_rdy, mem_re, mem_ra, out_*, done_*, err. Reads returning after reset release are ignored.
- No output backpressure: the consumer always accepts.

Optional Feature:
- Macro: LIST_WALK_LOOP_GUARD_EN.
- Defined:
  - Each slot keeps a hop counter, cleared at accept and incremented per emitted node.
  - Once a slot has emitted N nodes and its returned mem_rd is still !=0, the walk is aborted: no read is issued, done_vld=1 with err=1, and the slot is freed.
- Undefined: no counters; cyclic lists are walked forever and hold their slot; err is tied 0.

Test Plan:
- Memory next table {1:5, 5:3, 3:10, 10:0}, LAT=3; requester 0 start=1 at cycle 0 -> out_ptr 1,5,3,10 at cycles 1,4,7,10 with id 0; done id 0 at cycle 13.
- All 4 requesters valid from reset with starts 7, 6, 2, 9 (table 7:15, 15:8, 2:4, 9:14, 14:11, 11:13, 13:12, others 0) -> grants to 0, 1, 2 in cycles 0, 1, 2; requester 3 granted at cycle 4 into slot 1, which frees immediately after node 6 returns 0; one mem_re every cycle while demand exists.
- Requester 2 start=0 -> accepted, no mem_re, done id 2 the next cycle, no out_vld.
- Reset asserted mid-walk with 3 slots busy -> all outputs 0 immediately; after release, stale mem_rd values cause no output; a fresh request completes normally.
- With LIST_WALK_LOOP_GUARD_EN, cyclic list 4:8, 8:4 -> 16 out_vld pulses, then done with err=1 and the slot is reusable. Without the macro -> alternating 4,8 indefinitely and no done.
- Requesters 1 and 3 continuously valid, single free slot each phase -> grants alternate 1, 3, 1, 3 (no starvation).
